// File: rtl/mem_ctrl_if.sv
// Bus bundle for mem_ctrl: fetch port, data-side port and the byte-wide RAM port.
// The controller takes the slave view; the surrounding system takes the master view.
interface mem_ctrl_if #(
   parameter int ADDR_W = 17
);
   // fetch side
   logic              if_req_i;
   logic [31:0]       if_addr_i;
   logic [7:0]        if_data_o;
   logic              if_stall_o;
   // data (load/store) side
   logic              mem_req_i;
   logic              mem_we_i;
   logic [1:0]        mem_width_i;
   logic [31:0]       mem_addr_i;
   logic [31:0]       mem_wdata_i;
   logic [31:0]       mem_rdata_o;
   logic              mem_done_o;
   logic              mem_busy_o;
   // RAM side
   logic [ADDR_W-1:0] ram_addr_o;
   logic              ram_we_o;
   logic [7:0]        ram_dout_o;
   logic [7:0]        ram_din_i;

   modport slave (
      input  if_req_i, if_addr_i,
      output if_data_o, if_stall_o,
      input  mem_req_i, mem_we_i, mem_width_i, mem_addr_i, mem_wdata_i,
      output mem_rdata_o, mem_done_o, mem_busy_o,
      output ram_addr_o, ram_we_o, ram_dout_o,
      input  ram_din_i
   );

   modport master (
      output if_req_i, if_addr_i,
      input  if_data_o, if_stall_o,
      output mem_req_i, mem_we_i, mem_width_i, mem_addr_i, mem_wdata_i,
      input  mem_rdata_o, mem_done_o, mem_busy_o,
      input  ram_addr_o, ram_we_o, ram_dout_o,
      output ram_din_i
   );
endinterface

// File: rtl/mem_ctrl.sv
// Single-port byte RAM controller: fetch gets the port whenever the data side
// is not sequencing bytes; data-side loads/stores of 1/2/4 bytes are run here
// one byte per cycle and finish with a registered done pulse.
module mem_ctrl #(
   parameter int ADDR_W = 17
) (
   input  logic      clk,
   input  logic      rst,
   mem_ctrl_if.slave bus
);

   typedef enum logic [1:0] {IDLE, RD, RD_TAIL, WR} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] base;
   logic [1:0]        width;
   logic [31:0]       wdata;
   logic [31:0]       asm_q, asm_nx;
   logic [1:0]        cnt;
   logic              done;
   logic [31:0]       rdata;
   logic [1:0]        last;
   logic [1:0]        lane;
   logic              accept;
   logic [ADDR_W-1:0] data_addr;

   // address bits above the RAM size are dropped on purpose
   logic unused_addr_bits;
   assign unused_addr_bits = ^{bus.if_addr_i[31:ADDR_W], bus.mem_addr_i[31:ADDR_W]};

   // index of the final byte: width 11 behaves like a word
   assign last = (width == 2'b00) ? 2'd0 : (width == 2'b01) ? 2'd1 : 2'd3;

   // a request still high in the done cycle belongs to the finished transaction
   assign accept    = (state == IDLE) && bus.mem_req_i && !done;
   assign data_addr = base + ADDR_W'(cnt);

   // state register
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

   // next-state logic
   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (accept) state_nx = bus.mem_we_i ? WR : RD;
         RD:      if (cnt == last) state_nx = RD_TAIL;
         RD_TAIL: state_nx = IDLE;
         WR:      if (cnt == last) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // RAM port ownership: fetch in IDLE/RD_TAIL, data side in RD/WR
   always_comb begin
      bus.ram_addr_o = bus.if_addr_i[ADDR_W-1:0];
      bus.ram_we_o   = 1'b0;
      bus.ram_dout_o = 8'h00;
      bus.if_stall_o = 1'b0;
      if (!rst) begin
         case (state)
            RD: begin
               bus.ram_addr_o = data_addr;
               bus.if_stall_o = bus.if_req_i;
            end
            WR: begin
               bus.ram_addr_o = data_addr;
               bus.ram_we_o   = 1'b1;
               bus.ram_dout_o = wdata[{cnt, 3'b000} +: 8];
               bus.if_stall_o = bus.if_req_i;
            end
            default: ;
         endcase
      end
   end

   // read data arrives one cycle after its address, so it lands in lane cnt-1
   always_comb begin
      lane   = (state == RD_TAIL) ? last : cnt - 2'd1;
      asm_nx = asm_q;
      if ((state == RD && cnt != 2'd0) || state == RD_TAIL)
         asm_nx[{lane, 3'b000} +: 8] = bus.ram_din_i;
   end

   // transaction capture, byte counter, read assembly and done pulse
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt   <= 2'd0;
         done  <= 1'b0;
         rdata <= 32'h0;
         asm_q <= 32'h0;
         base  <= '0;
         width <= 2'b00;
         wdata <= 32'h0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (accept) begin
                  base  <= bus.mem_addr_i[ADDR_W-1:0];
                  width <= bus.mem_width_i;
                  wdata <= bus.mem_wdata_i;
                  asm_q <= 32'h0;
                  cnt   <= 2'd0;
               end
            end
            RD: begin
               asm_q <= asm_nx;
               if (cnt != last) cnt <= cnt + 2'd1;
            end
            RD_TAIL: begin
               rdata <= asm_nx;
               done  <= 1'b1;
            end
            WR: begin
               if (cnt == last) done <= 1'b1;
               else             cnt  <= cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

   assign bus.if_data_o   = bus.ram_din_i;
   assign bus.mem_rdata_o = rdata;
   assign bus.mem_done_o  = done;
   assign bus.mem_busy_o  = (state != IDLE);

endmodule

// File: tb/tb_mem_ctrl.sv
// Directed bench for mem_ctrl: stimulus queues expected per-cycle values and
// done events; a negedge monitor pops and compares them.
module tb_mem_ctrl;
   localparam int ADDR_W = 17;
   localparam logic [31:0] AMASK = (32'h1 << ADDR_W) - 1;

   localparam int K_DATA  = 0;
   localparam int K_STALL = 1;
   localparam int K_ADDR  = 2;
   localparam int K_WE    = 3;
   localparam int K_BUSY  = 4;
   localparam int K_DONE  = 5;
   localparam int K_RDATA = 6;
   localparam int K_RAM   = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   mem_ctrl_if #(.ADDR_W(ADDR_W)) bus();
   mem_ctrl #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

   // byte RAM with one-cycle read latency
   logic [7:0] ram [0:(1<<ADDR_W)-1];
   logic [7:0] din_q;
   always @(posedge clk) begin
      if (bus.ram_we_o) ram[bus.ram_addr_o] <= bus.ram_dout_o;
      din_q <= ram[bus.ram_addr_o];
   end
   assign bus.ram_din_i = din_q;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {int c; int kind; int addr; logic [31:0] val;} exp_t;
   typedef struct {int c; bit chk; logic [31:0] val;} done_t;
   exp_t  eq[$];
   done_t dq[$];
   int checks = 0;
   int failures = 0;

   function automatic string kname(int k);
      case (k)
         K_DATA:  return "if_data";
         K_STALL: return "if_stall";
         K_ADDR:  return "ram_addr";
         K_WE:    return "ram_we";
         K_BUSY:  return "mem_busy";
         K_DONE:  return "mem_done";
         K_RDATA: return "mem_rdata";
         default: return "ram_byte";
      endcase
   endfunction

   function automatic logic [31:0] sample(int k, int a);
      case (k)
         K_DATA:  return {24'h0, bus.if_data_o};
         K_STALL: return {31'h0, bus.if_stall_o};
         K_ADDR:  return 32'(bus.ram_addr_o);
         K_WE:    return {31'h0, bus.ram_we_o};
         K_BUSY:  return {31'h0, bus.mem_busy_o};
         K_DONE:  return {31'h0, bus.mem_done_o};
         K_RDATA: return bus.mem_rdata_o;
         default: return {24'h0, ram[a]};
      endcase
   endfunction

   task automatic expect_at(input int c, input int k, input logic [31:0] v, input int a = 0);
      exp_t e;
      e.c = c; e.kind = k; e.addr = a; e.val = v;
      eq.push_back(e);
   endtask

   // monitor: compares every expectation due this cycle and every done pulse
   logic [31:0] act;
   done_t       d;
   always @(negedge clk) begin
      for (int i = eq.size() - 1; i >= 0; i--) begin
         if (eq[i].c <= cyc) begin
            checks++;
            act = sample(eq[i].kind, eq[i].addr);
            if (eq[i].c < cyc) begin
               failures++;
               $display("FAIL %s stale expectation for cyc %0d", kname(eq[i].kind), eq[i].c);
            end else if (act !== eq[i].val) begin
               failures++;
               $display("FAIL %s cyc=%0d addr=%0h got=%0h expected=%0h",
                        kname(eq[i].kind), cyc, eq[i].addr, act, eq[i].val);
            end
            eq.delete(i);
         end
      end
      while (dq.size() > 0 && dq[0].c < cyc) begin
         d = dq.pop_front();
         checks++;
         failures++;
         $display("FAIL done_missing expected at cyc %0d, still absent at cyc %0d", d.c, cyc);
      end
      if (bus.mem_done_o === 1'b1) begin
         checks++;
         if (dq.size() == 0) begin
            failures++;
            $display("FAIL done_unexpected cyc=%0d got=1 expected=0", cyc);
         end else begin
            d = dq.pop_front();
            if (d.c != cyc) begin
               failures++;
               $display("FAIL done_cycle got=%0d expected=%0d", cyc, d.c);
            end else if (d.chk && bus.mem_rdata_o !== d.val) begin
               failures++;
               $display("FAIL load_rdata cyc=%0d got=%h expected=%h", cyc, bus.mem_rdata_o, d.val);
            end
         end
      end
   end

   // fetch stage: walks addresses, holds while stalled
   int f_base = 0, f_num = 0, f_start = 0;
   int f_seen = 0, f_addr = 0, f_left = 0;
   bit f_take = 1'b0;
   initial begin
      bus.if_req_i  = 1'b0;
      bus.if_addr_i = 32'h0;
      forever begin
         @(posedge clk);
         #2;
         if (f_take) begin f_addr++; f_left--; end
         if (f_start != f_seen) begin
            f_seen = f_start; f_addr = f_base; f_left = f_num;
         end
         bus.if_req_i  = (f_left > 0);
         bus.if_addr_i = f_addr;
         @(negedge clk);
         f_take = bus.if_req_i && !bus.if_stall_o;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic start_fetch(input int base, input int num);
      f_base = base; f_num = num; f_start++;
   endtask

   // issue one data-side transaction starting in the current cycle
   task automatic run_mem(input bit we, input logic [1:0] w, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] exp_rd, input bit drop);
      int A, n, dc;
      done_t dn;
      A  = cyc;
      n  = (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
      dc = A + n + (we ? 1 : 2);
      bus.mem_req_i   = 1'b1;
      bus.mem_we_i    = we;
      bus.mem_width_i = w;
      bus.mem_addr_i  = a;
      bus.mem_wdata_i = wd;
      dn.c = dc; dn.chk = !we; dn.val = exp_rd;
      dq.push_back(dn);
      for (int k = 0; k < n; k++) begin
         expect_at(A + 1 + k, K_ADDR, (a + 32'(k)) & AMASK);
         expect_at(A + 1 + k, K_WE, {31'h0, we});
      end
      expect_at(A + 1, K_BUSY, 32'h1);
      expect_at(dc, K_BUSY, 32'h0);
      while (cyc < dc) step();
      step();
      if (drop) bus.mem_req_i = 1'b0;
   endtask

   initial begin
      int t, A;
      for (int i = 0; i < (1 << ADDR_W); i++) ram[i] = 8'h00;
      ram[32'h100] = 8'h13; ram[32'h101] = 8'h00; ram[32'h102] = 8'h00; ram[32'h103] = 8'h93;
      ram[32'h200] = 8'hEF; ram[32'h201] = 8'hBE; ram[32'h202] = 8'hAD; ram[32'h203] = 8'hDE;
      for (int i = 0; i < 8; i++) ram[32'h400 + i] = 8'h40 + 8'(i);
      for (int i = 0; i < 4; i++) ram[32'h500 + i] = 8'h77;
      bus.mem_req_i = 1'b0; bus.mem_we_i = 1'b0; bus.mem_width_i = 2'b00;
      bus.mem_addr_i = 32'h0; bus.mem_wdata_i = 32'h0;

      // reset: fetch and a store both requesting, nothing may happen
      step();
      start_fetch(32'h100, 3);
      bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_width_i = 2'b10;
      bus.mem_addr_i = 32'h600; bus.mem_wdata_i = 32'hFFFFFFFF;
      for (int c = cyc; c < cyc + 2; c++) begin
         expect_at(c, K_WE, 32'h0);
         expect_at(c, K_STALL, 32'h0);
         expect_at(c, K_BUSY, 32'h0);
         expect_at(c, K_DONE, 32'h0);
         expect_at(c, K_RDATA, 32'h0);
      end
      step(); step();
      rst = 1'b0;
      bus.mem_req_i = 1'b0;
      expect_at(cyc, K_BUSY, 32'h0);
      expect_at(cyc + 1, K_BUSY, 32'h0);
      expect_at(cyc + 1, K_RAM, 32'h00, 32'h600);
      step(); step(); step();

      // fetch only
      t = cyc;
      start_fetch(32'h100, 4);
      for (int i = 0; i < 4; i++) expect_at(t + i, K_STALL, 32'h0);
      expect_at(t + 1, K_DATA, 32'h13);
      expect_at(t + 2, K_DATA, 32'h00);
      expect_at(t + 3, K_DATA, 32'h00);
      expect_at(t + 4, K_DATA, 32'h93);
      while (cyc < t + 6) step();

      // word load, request held through done then dropped
      run_mem(1'b0, 2'b10, 32'h200, 32'h0, 32'hDEADBEEF, 1'b1);
      expect_at(cyc, K_BUSY, 32'h0);
      expect_at(cyc + 1, K_BUSY, 32'h0);
      step(); step();

      // byte store, then half store back-to-back with a word load
      run_mem(1'b1, 2'b00, 32'h300, 32'h000000AA, 32'h0, 1'b1);
      expect_at(cyc, K_RAM, 32'hAA, 32'h300);
      step();
      run_mem(1'b1, 2'b01, 32'h301, 32'h00001234, 32'h0, 1'b0);
      expect_at(cyc, K_RAM, 32'h34, 32'h301);
      expect_at(cyc, K_RAM, 32'h12, 32'h302);
      run_mem(1'b0, 2'b10, 32'h300, 32'h0, 32'h001234AA, 1'b1);
      step();

      // narrow loads zero-fill; width 11 acts as word
      run_mem(1'b0, 2'b00, 32'h203, 32'h0, 32'h000000DE, 1'b1);
      run_mem(1'b0, 2'b01, 32'h200, 32'h0, 32'h0000BEEF, 1'b1);
      run_mem(1'b0, 2'b11, 32'h200, 32'h0, 32'hDEADBEEF, 1'b1);
      step();

      // half store straddling the top of RAM with junk upper address bits
      run_mem(1'b1, 2'b01, 32'hABC1FFFF, 32'h00005566, 32'h0, 1'b1);
      expect_at(cyc, K_RAM, 32'h66, 32'h1FFFF);
      expect_at(cyc, K_RAM, 32'h55, 32'h0);
      step();

      // contention: fetch streaming from 0x400 while a word load runs
      t = cyc;
      A = t + 2;
      start_fetch(32'h400, 6);
      expect_at(t + 1, K_DATA, 32'h40);
      expect_at(t + 2, K_DATA, 32'h41);
      expect_at(A, K_STALL, 32'h0);
      expect_at(A + 1, K_DATA, 32'h42);
      for (int i = 1; i <= 4; i++) expect_at(A + i, K_STALL, 32'h1);
      expect_at(A + 5, K_STALL, 32'h0);
      expect_at(A + 5, K_ADDR, 32'h403);
      expect_at(A + 6, K_DATA, 32'h43);
      expect_at(A + 7, K_DATA, 32'h44);
      expect_at(A + 8, K_DATA, 32'h45);
      step(); step();
      run_mem(1'b0, 2'b10, 32'h200, 32'h0, 32'hDEADBEEF, 1'b1);
      step(); step(); step();

      // reset lands in the cycle after the second byte of a word store
      A = cyc;
      bus.mem_req_i = 1'b1; bus.mem_we_i = 1'b1; bus.mem_width_i = 2'b10;
      bus.mem_addr_i = 32'h500; bus.mem_wdata_i = 32'h44332211;
      expect_at(A + 1, K_WE, 32'h1);
      expect_at(A + 2, K_WE, 32'h1);
      expect_at(A + 3, K_WE, 32'h0);
      expect_at(A + 3, K_STALL, 32'h0);
      for (int i = 4; i <= 6; i++) begin
         expect_at(A + i, K_BUSY, 32'h0);
         expect_at(A + i, K_DONE, 32'h0);
      end
      expect_at(A + 6, K_RAM, 32'h11, 32'h500);
      expect_at(A + 6, K_RAM, 32'h22, 32'h501);
      expect_at(A + 6, K_RAM, 32'h77, 32'h502);
      expect_at(A + 6, K_RAM, 32'h77, 32'h503);
      while (cyc < A + 3) step();
      rst = 1'b1;
      bus.mem_req_i = 1'b0;
      step();
      rst = 1'b0;
      while (cyc < A + 10) step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
